// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - default sizing constants shared by the FIFO and its bench
package fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_MEM_SIZE   = 32;
    localparam int DEF_DEPTH      = 2 ** DEF_ADDR_WIDTH;

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - FIFO storage array, synchronous write, asynchronous read
module fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int MEM_SIZE   = 32,
    parameter int MEM_AW     = 5
) (
    input  logic                  clk_i,
    input  logic                  w_en_i,
    input  logic [MEM_AW-1:0]     w_addr_i,
    input  logic [DATA_WIDTH-1:0] w_data_i,
    input  logic [MEM_AW-1:0]     r_addr_i,
    output logic [DATA_WIDTH-1:0] r_data_o
);

    logic [DATA_WIDTH-1:0] MEM [MEM_SIZE-1:0];

    always_ff @(posedge clk_i) begin
        if (w_en_i) begin
            MEM[w_addr_i] <= w_data_i;
        end
    end

    assign r_data_o = MEM[r_addr_i];

endmodule

// File: rtl/fifo.sv
// rtl/fifo.sv - single-clock first-word-fall-through FIFO with FULL/EMPTY flags
module fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int MEM_SIZE   = DEF_MEM_SIZE
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  W_INC,
    input  logic [DATA_WIDTH-1:0] WR_DATA,
    output logic                  FULL,
    input  logic                  R_INC,
    output logic [DATA_WIDTH-1:0] RD_DATA,
    output logic                  EMPTY
);

    localparam int MEM_AW = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

    logic [ADDR_WIDTH:0]   wptr_q, wptr_d;
    logic [ADDR_WIDTH:0]   rptr_q, rptr_d;
    logic                  wr_en;
    logic                  rd_en;
    logic [MEM_AW-1:0]     wr_mem_addr;
    logic [MEM_AW-1:0]     rd_mem_addr;

    // The extra pointer MSB distinguishes a full wrap from an empty queue.
    assign EMPTY = (wptr_q == rptr_q);
    assign FULL  = (wptr_q[ADDR_WIDTH] != rptr_q[ADDR_WIDTH]) &&
                   (wptr_q[ADDR_WIDTH-1:0] == rptr_q[ADDR_WIDTH-1:0]);

    always_comb begin
        wr_en  = W_INC && !FULL;
        rd_en  = R_INC && !EMPTY;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (wr_en) begin
            wptr_d = wptr_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
        end
        if (rd_en) begin
            rptr_d = rptr_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    assign wr_mem_addr = MEM_AW'(wptr_q[ADDR_WIDTH-1:0]);
    assign rd_mem_addr = MEM_AW'(rptr_q[ADDR_WIDTH-1:0]);

    // Reset wins over a coincident write so a discarded word never lands in memory.
    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_SIZE   (MEM_SIZE),
        .MEM_AW     (MEM_AW)
    ) FIFO_MEMORY (
        .clk_i    (CLK),
        .w_en_i   (wr_en && RST),
        .w_addr_i (wr_mem_addr),
        .w_data_i (WR_DATA),
        .r_addr_i (rd_mem_addr),
        .r_data_o (RD_DATA)
    );

endmodule

// File: tb/tb_fifo.sv
// tb/tb_fifo.sv - directed self-checking bench for fifo
module tb_fifo;
    import fifo_pkg::*;

    localparam int DW = DEF_DATA_WIDTH;
    localparam int AW = DEF_ADDR_WIDTH;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          W_INC = 1'b0;
    logic          R_INC = 1'b0;
    logic [DW-1:0] WR_DATA = '0;
    logic [DW-1:0] RD_DATA;
    logic          FULL;
    logic          EMPTY;

    int passed = 0;
    int total  = 0;

    fifo dut (
        .CLK     (CLK),
        .RST     (RST),
        .W_INC   (W_INC),
        .WR_DATA (WR_DATA),
        .FULL    (FULL),
        .R_INC   (R_INC),
        .RD_DATA (RD_DATA),
        .EMPTY   (EMPTY)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] waddr();
        return 32'(dut.wptr_q[AW-1:0]);
    endfunction

    function automatic logic [31:0] raddr();
        return 32'(dut.rptr_q[AW-1:0]);
    endfunction

    initial begin
        // Reset
        #1;
        tick();
        RST = 1'b1;
        check("rst_empty", 32'(EMPTY), 32'd1);
        check("rst_full", 32'(FULL), 32'd0);
        check("rst_waddr", waddr(), 32'd0);
        check("rst_raddr", raddr(), 32'd0);

        // Packet write 0x01..0x0A
        W_INC = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            WR_DATA = DW'(i);
            tick();
            if (i == 1) begin
                check("first_word_empty", 32'(EMPTY), 32'd0);
                check("first_word_data", 32'(RD_DATA), 32'h01);
            end
        end
        W_INC = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("pkt_mem", 32'(dut.FIFO_MEMORY.MEM[i]), 32'(i + 1));
        end
        check("pkt_waddr", waddr(), 32'd10);
        check("pkt_empty", 32'(EMPTY), 32'd0);
        check("pkt_full", 32'(FULL), 32'd0);
        check("pkt_head", 32'(RD_DATA), 32'h01);

        // Packet read
        R_INC = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            check("pkt_read", 32'(RD_DATA), 32'(i));
            tick();
        end
        R_INC = 1'b0;
        check("pkt_read_empty", 32'(EMPTY), 32'd1);

        // Fill to FULL, then overflow attempt
        W_INC = 1'b1;
        for (int i = 0; i < DEF_DEPTH; i++) begin
            WR_DATA = DW'(32'h10 + i);
            tick();
            if (i == DEF_DEPTH - 2) check("full_not_yet", 32'(FULL), 32'd0);
        end
        check("fill_full", 32'(FULL), 32'd1);
        WR_DATA = 8'hFF;
        tick();
        W_INC = 1'b0;
        check("ovf_full", 32'(FULL), 32'd1);
        check("ovf_waddr", waddr(), 32'd10);
        check("ovf_mem", 32'(dut.FIFO_MEMORY.MEM[10]), 32'h10);

        // Drain
        R_INC = 1'b1;
        for (int i = 0; i < DEF_DEPTH; i++) begin
            check("drain", 32'(RD_DATA), 32'h10 + 32'(i));
            tick();
        end
        R_INC = 1'b0;
        check("drain_empty", 32'(EMPTY), 32'd1);

        // Underflow after fresh reset
        RST = 1'b0;
        tick();
        RST = 1'b1;
        R_INC = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("unf_raddr", raddr(), 32'd0);
            check("unf_empty", 32'(EMPTY), 32'd1);
        end

        // Simultaneous read/write while EMPTY: write only
        W_INC = 1'b1;
        WR_DATA = 8'h55;
        tick();
        check("wr_on_empty_empty", 32'(EMPTY), 32'd0);
        check("wr_on_empty_data", 32'(RD_DATA), 32'h55);
        check("wr_on_empty_raddr", raddr(), 32'd0);

        // Stream 40 words at occupancy 1 across the wrap
        for (int i = 0; i < 40; i++) begin
            check("stream_head", 32'(RD_DATA), (i == 0) ? 32'h55 : 32'h80 + 32'(i - 1));
            WR_DATA = DW'(32'h80 + i);
            tick();
            check("stream_empty", 32'(EMPTY), 32'd0);
            check("stream_full", 32'(FULL), 32'd0);
        end
        R_INC = 1'b0;
        check("stream_last", 32'(RD_DATA), 32'hA7);
        check("stream_raddr", raddr(), 32'd8);

        // Fill to FULL from occupancy 1, then concurrent read/write
        for (int i = 0; i < DEF_DEPTH - 1; i++) begin
            WR_DATA = DW'(32'h60 + i);
            tick();
        end
        check("refill_full", 32'(FULL), 32'd1);
        R_INC = 1'b1;
        WR_DATA = 8'hEE;
        tick();
        W_INC = 1'b0;
        check("rw_full_full", 32'(FULL), 32'd0);
        check("rw_full_head", 32'(RD_DATA), 32'h60);
        check("rw_full_waddr", waddr(), 32'd8);
        for (int i = 0; i < DEF_DEPTH - 1; i++) begin
            check("rw_full_drain", 32'(RD_DATA), 32'h60 + 32'(i));
            tick();
        end
        R_INC = 1'b0;
        check("rw_full_empty", 32'(EMPTY), 32'd1);

        // Reset mid-stream
        W_INC = 1'b1;
        for (int i = 0; i < 3; i++) begin
            WR_DATA = DW'(32'hC0 + i);
            tick();
        end
        R_INC = 1'b1;
        RST = 1'b0;
        tick();
        RST = 1'b1;
        W_INC = 1'b0;
        R_INC = 1'b0;
        check("midrst_empty", 32'(EMPTY), 32'd1);
        check("midrst_full", 32'(FULL), 32'd0);
        check("midrst_waddr", waddr(), 32'd0);
        check("midrst_raddr", raddr(), 32'd0);
        tick();
        check("midrst_hold", 32'(EMPTY), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
